mac_dot_accumulator: RTL

Downstream consumer of the dual-product MAC stage in the attention datapath. Takes one `{carry, sum}` beat per cycle from the MAC output and accumulates a programmable number of beats into one dot-product result. Presents the result on a valid/ready output toward the softmax/score buffer. A new vector starts on a `start` pulse.

---
 rtl/mac_dot_accumulator_pkg.sv | 14 +
 rtl/mac_dot_accumulator_if.sv | 30 +++
 rtl/mac_dot_accumulator_acc_add_sat.sv | 24 ++
 rtl/mac_dot_accumulator.sv | 83 ++++++++
 4 files changed

// File: rtl/mac_dot_accumulator_pkg.sv
// Shared definitions for the MAC dot-product accumulator: default widths and FSM state encoding.
package mac_dot_accumulator_pkg;

   localparam int PROD_WIDTH_DEF = 16;
   localparam int ACC_WIDTH_DEF  = 32;
   localparam int CNT_WIDTH_DEF  = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

endpackage

// File: rtl/mac_dot_accumulator_if.sv
// Control, MAC-beat input and result output signals of mac_dot_accumulator.
// Handshake rule for both in_* and out_*: a transfer happens on a rising clk edge where
// valid && ready; the source holds its payload stable until then, and ready may depend on state only.
interface mac_dot_accumulator_if #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int CNT_WIDTH  = 10
);
   logic                  start;
   logic [CNT_WIDTH-1:0]  len;
   logic                  busy;
   logic                  in_valid;
   logic                  in_ready;
   logic [PROD_WIDTH-1:0] in_sum;
   logic                  in_carry;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  out_data;
   logic                  out_ovf;

   modport master (
      output start, len, in_valid, in_sum, in_carry, out_ready,
      input  busy, in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  start, len, in_valid, in_sum, in_carry, out_ready,
      output busy, in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/mac_dot_accumulator_acc_add_sat.sv
// Combinational accumulator adder with carry-out detection.
// ACC_SATURATE_EN defined: clamp to all-ones on carry-out; undefined: wrap modulo 2^ACC_WIDTH.
module acc_add_sat
   import mac_dot_accumulator_pkg::*;
#(
   parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [ACC_WIDTH-1:0] beat,
   output logic [ACC_WIDTH-1:0] acc_nxt,
   output logic                 ovf
);
   logic [ACC_WIDTH:0] sum;

   assign sum = {1'b0, acc} + {1'b0, beat};
   assign ovf = sum[ACC_WIDTH];

`ifdef ACC_SATURATE_EN
   // Once clamped, any further nonzero beat carries out again, so the value stays pinned.
   assign acc_nxt = ovf ? '1 : sum[ACC_WIDTH-1:0];
`else
   assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif
endmodule

// File: rtl/mac_dot_accumulator.sv
// Accumulates len {carry,sum} MAC beats into one dot-product result with a valid/ready output.
// Overflow behaviour is selected by ACC_SATURATE_EN (see acc_add_sat).
module mac_dot_accumulator
   import mac_dot_accumulator_pkg::*;
#(
   parameter int PROD_WIDTH = PROD_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   mac_dot_accumulator_if.slave  bus,
   output logic [1:0]            state_dbg
);
   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ACCUM = ST_ACCUM;
   localparam logic [1:0] S_OUT   = ST_OUT;

   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] len_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] acc_nxt;
   logic [ACC_WIDTH-1:0] beat;
   logic                 ovf;
   logic                 add_ovf;
   logic                 accept;
   logic                 last_beat;

   assign beat      = ACC_WIDTH'({bus.in_carry, bus.in_sum});
   assign accept    = bus.in_valid && (state == S_ACCUM);
   // cnt counts beats already taken, so the current beat is number cnt+1.
   assign last_beat = (cnt + CNT_WIDTH'(1)) == len_q;

   acc_add_sat #(.ACC_WIDTH(ACC_WIDTH)) u_acc_add_sat (
      .acc     (acc),
      .beat    (beat),
      .acc_nxt (acc_nxt),
      .ovf     (add_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         len_q <= '0;
         cnt   <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  len_q <= bus.len;
                  cnt   <= '0;
                  acc   <= '0;
                  ovf   <= 1'b0;
                  state <= (bus.len == '0) ? S_OUT : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc <= acc_nxt;
                  ovf <= ovf | add_ovf;
                  cnt <= cnt + CNT_WIDTH'(1);
                  if (last_beat) state <= S_OUT;
               end
            end
            S_OUT: begin
               if (bus.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The result register is the accumulator itself; it is only cleared by the next start.
   assign bus.out_data  = acc;
   assign bus.out_ovf   = ovf;
   assign bus.in_ready  = (state == S_ACCUM);
   assign bus.out_valid = (state == S_OUT);
   assign bus.busy      = (state != S_IDLE);
   assign state_dbg     = state;
endmodule
